// File: rtl/dvp_capture_pkg.sv
// Shared definitions for the DVP capture front end and later pipeline stages.
package dvp_capture_pkg;

  // Frame-level capture states.
  typedef enum logic [1:0] {
    S_SKIP = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } dvp_state_e;

  localparam int unsigned RGB565_W  = 16;
  localparam int unsigned DEF_H_ACT = 640;
  localparam int unsigned DEF_V_ACT = 480;

  // Sensor sends the high byte of each pixel first.
  function automatic logic [RGB565_W-1:0] rgb565_pack(input logic [7:0] hi,
                                                      input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// Packs sensor byte pairs into RGB565 words and flags line ends.
// All outputs are registered one cycle after the byte is presented.
module dvp_byte_packer
  import dvp_capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                href_i,
  input  logic [7:0]          data_i,
  output logic [RGB565_W-1:0] word_o,
  output logic                valid_o,
  output logic                odd_o,
  output logic                line_end_o
);

  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic                href_prev_q;
  logic                got_byte_q, got_byte_d;
  logic [RGB565_W-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                odd_q, odd_d;
  logic                line_end_q, line_end_d;

  // Byte phase tracking, pixel assembly and line-end detection.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    phase_d    = 1'b0;
    hi_d       = hi_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    odd_d      = 1'b0;
    line_end_d = 1'b0;
    got_byte_d = got_byte_q;
    if (en_i) begin
      if (href_i) begin
        got_byte_d = 1'b1;
        if (!phase_q) begin
          hi_d    = data_i;
          phase_d = 1'b1;
        end else begin
          word_d  = rgb565_pack(hi_q, data_i);
          valid_d = 1'b1;
        end
      end else if (href_prev_q) begin
        // Phase still 1 here means the line ended on an unpaired byte.
        line_end_d = got_byte_q;
        odd_d      = got_byte_q & phase_q;
        got_byte_d = 1'b0;
      end
    end else begin
      got_byte_d = 1'b0;
    end
  end

  // Packer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together on the edge regardless of statement order.
    if (!rst_n) begin
      // NOTE: data registers are reset too so the pixel word reads 0 after reset.
      phase_q     <= 1'b0;
      hi_q        <= '0;
      href_prev_q <= 1'b0;
      got_byte_q  <= 1'b0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      odd_q       <= 1'b0;
      line_end_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      href_prev_q <= href_i;
      got_byte_q  <= got_byte_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      odd_q       <= odd_d;
      line_end_q  <= line_end_d;
    end
  end

  assign word_o     = word_q;
  assign valid_o    = valid_q;
  assign odd_o      = odd_q;
  assign line_end_o = line_end_q;

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: input registering, settle-frame skipping, RGB565
// packing, gated output stream and per-frame geometry checking.
module dvp_capture
  import dvp_capture_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned H_ACT      = DEF_H_ACT,
  parameter int unsigned V_ACT      = DEF_V_ACT,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_data,
  output logic                dvp_vsync,
  output logic                dvp_href,
  output logic                dvp_valid,
  output logic [RGB565_W-1:0] dvp_data,
  output logic                frame_done,
  output logic [CNT_W-1:0]    line_cnt,
  output logic                size_err
);

  localparam int unsigned SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Input stage (s0) and one further stage (s1) aligned with packer outputs.
  logic       s0_vs_q, s0_href_q;
  logic [7:0] s0_data_q;
  logic       s1_vs_q, s1_href_q;
  logic       vs_rise_q, vs_fall_q;

  // Packer outputs.
  logic [RGB565_W-1:0] pk_word;
  logic                pk_valid, pk_odd, pk_line_end;

  // Frame state and counters.
  dvp_state_e          state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [CNT_W-1:0]    pix_q, pix_d, line_q, line_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    pix_acc, line_acc;
  logic                err_acc;

  // Output registers.
  logic                dvp_vsync_q, dvp_vsync_d;
  logic                dvp_href_q, dvp_href_d;
  logic                dvp_valid_q, dvp_valid_d;
  logic [RGB565_W-1:0] dvp_data_q, dvp_data_d;
  logic                frame_done_q, frame_done_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic                size_err_q, size_err_d;

  // Register camera pins and detect vsync edges; s1_vs_q is s0 one cycle back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_vs_q   <= 1'b0;
      s0_href_q <= 1'b0;
      s0_data_q <= '0;
      s1_vs_q   <= 1'b0;
      s1_href_q <= 1'b0;
      vs_rise_q <= 1'b0;
      vs_fall_q <= 1'b0;
    end else begin
      s0_vs_q   <= cam_vsync;
      s0_href_q <= cam_href;
      s0_data_q <= cam_data;
      s1_vs_q   <= s0_vs_q;
      s1_href_q <= s0_href_q;
      vs_rise_q <= s0_vs_q & ~s1_vs_q;
      vs_fall_q <= ~s0_vs_q & s1_vs_q;
    end
  end

  dvp_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == S_CAPT),
    .href_i     (s0_href_q),
    .data_i     (s0_data_q),
    .word_o     (pk_word),
    .valid_o    (pk_valid),
    .odd_o      (pk_odd),
    .line_end_o (pk_line_end)
  );

  // Fold this cycle's pixel and line-end into the running frame counters,
  // so a frame end coinciding with them still accounts for them.
  always_comb begin
    pix_acc  = pix_q;
    line_acc = line_q;
    err_acc  = err_q;
    if (pk_valid) begin
      if (pix_q == CNT_MAX) err_acc = 1'b1;
      else                  pix_acc = pix_q + 1'b1;
    end
    if (pk_line_end) begin
      if ((pix_acc != CNT_W'(H_ACT)) || pk_odd) err_acc = 1'b1;
      if (line_q == CNT_MAX) err_acc  = 1'b1;
      else                   line_acc = line_q + 1'b1;
      pix_acc = '0;
    end
  end

  // Frame FSM next state, counter updates and gated output stream.
  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    pix_d        = pix_q;
    line_d       = line_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    line_cnt_d   = line_cnt_q;
    size_err_d   = size_err_q;
    dvp_vsync_d  = 1'b0;
    dvp_href_d   = 1'b0;
    dvp_valid_d  = 1'b0;
    dvp_data_d   = dvp_data_q;
    case (state_q)
      S_SKIP: begin
        if (FRAME_SKIP == 0) begin
          state_d = S_WAIT;
        end else if (vs_rise_q) begin
          skip_d = skip_q + SKIP_W'(1);
          if (skip_d == SKIP_W'(FRAME_SKIP)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (vs_fall_q) begin
          state_d = S_CAPT;
          pix_d   = '0;
          line_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_CAPT: begin
        dvp_vsync_d = s1_vs_q;
        dvp_href_d  = s1_href_q;
        dvp_valid_d = pk_valid;
        if (pk_valid) dvp_data_d = pk_word;
        if (vs_rise_q) begin
          frame_done_d = 1'b1;
          line_cnt_d   = line_acc;
          size_err_d   = err_acc | (line_acc != CNT_W'(V_ACT));
          pix_d        = '0;
          line_d       = '0;
          err_d        = 1'b0;
        end else begin
          pix_d  = pix_acc;
          line_d = line_acc;
          err_d  = err_acc;
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  // Frame state, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_SKIP;
      skip_q       <= '0;
      pix_q        <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      dvp_vsync_q  <= 1'b0;
      dvp_href_q   <= 1'b0;
      dvp_valid_q  <= 1'b0;
      dvp_data_q   <= '0;
      frame_done_q <= 1'b0;
      line_cnt_q   <= '0;
      size_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      err_q        <= err_d;
      dvp_vsync_q  <= dvp_vsync_d;
      dvp_href_q   <= dvp_href_d;
      dvp_valid_q  <= dvp_valid_d;
      dvp_data_q   <= dvp_data_d;
      frame_done_q <= frame_done_d;
      line_cnt_q   <= line_cnt_d;
      size_err_q   <= size_err_d;
    end
  end

  assign dvp_vsync  = dvp_vsync_q;
  assign dvp_href   = dvp_href_q;
  assign dvp_valid  = dvp_valid_q;
  assign dvp_data   = dvp_data_q;
  assign frame_done = frame_done_q;
  assign line_cnt   = line_cnt_q;
  assign size_err   = size_err_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Self-checking bench for dvp_capture: table of frames plus scoreboard queues
// for pixels and frame status, and hand-written reset/latency sequences.
module tb_dvp_capture;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n, rst0_n;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_data;

  logic          dvp_vsync, dvp_href, dvp_valid, frame_done, size_err;
  logic [15:0]   dvp_data;
  logic [CW-1:0] line_cnt;

  logic          dvp_vsync0, dvp_href0, dvp_valid0, frame_done0, size_err0;
  logic [15:0]   dvp_data0;
  logic [CW-1:0] line_cnt0;

  always #5 clk = ~clk;

  dvp_capture #(.FRAME_SKIP(2), .H_ACT(4), .V_ACT(2), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_valid(dvp_valid), .dvp_data(dvp_data), .frame_done(frame_done),
    .line_cnt(line_cnt), .size_err(size_err)
  );

  dvp_capture #(.FRAME_SKIP(0), .H_ACT(4), .V_ACT(2), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .dvp_vsync(dvp_vsync0), .dvp_href(dvp_href0),
    .dvp_valid(dvp_valid0), .dvp_data(dvp_data0), .frame_done(frame_done0),
    .line_cnt(line_cnt0), .size_err(size_err0)
  );

  typedef struct {
    int n_lines;
    int n_bytes;
    int short_line;  // line carrying one byte fewer, -1 for none
    bit capt;        // frame expected to be captured
    int exp_lines;
    bit exp_err;
  } frame_vec_t;

  typedef struct {
    logic [CW-1:0] lines;
    logic          err;
  } fd_exp_t;

  logic [15:0] pix_q[$];
  fd_exp_t     fd_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
  endtask

  function automatic logic [7:0] byte_val(input int f, input int l, input int k);
    case (k)
      0:       return 8'hF8;
      1:       return 8'h00;
      2:       return 8'h07;
      3:       return 8'hE0;
      default: return 8'(f * 53 + l * 29 + k * 7);
    endcase
  endfunction

  // Scoreboard side for the FRAME_SKIP=2 instance.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin : mon
    logic [15:0] exp_pix;
    fd_exp_t     exp_fd;
    if (dvp_valid) begin
      check("valid_inside_href", {31'd0, dvp_href}, 32'd1);
      check("valid_spacing", {31'd0, prev_valid}, 32'd0);
      if (pix_q.size() == 0) fail_event("unexpected_valid");
      else begin
        exp_pix = pix_q.pop_front();
        check("pixel_data", {16'd0, dvp_data}, {16'd0, exp_pix});
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) fail_event("unexpected_frame_done");
      else begin
        exp_fd = fd_q.pop_front();
        check("fd_line_cnt", {20'd0, line_cnt}, {20'd0, exp_fd.lines});
        check("fd_size_err", {31'd0, size_err}, {31'd0, exp_fd.err});
      end
    end
    prev_valid <= dvp_valid;
  end

  // Simple tally for the FRAME_SKIP=0 instance.
  int            v0_cnt = 0;
  int            fd0_cnt = 0;
  logic [15:0]   last0 = '0;
  logic [CW-1:0] fd0_lines = '0;
  logic          fd0_err = 1'b0;
  always @(negedge clk) begin
    if (dvp_valid0) begin
      v0_cnt <= v0_cnt + 1;
      last0  <= dvp_data0;
    end
    if (frame_done0) begin
      fd0_cnt   <= fd0_cnt + 1;
      fd0_lines <= line_cnt0;
      fd0_err   <= size_err0;
    end
  end

  task automatic send_line(input int f, input int l, input int nbytes,
                           input bit capt, input bit lat);
    logic [7:0] hi, b;
    hi = '0;
    for (int k = 0; k < nbytes; k++) begin
      @(negedge clk);
      b = byte_val(f, l, k);
      cam_href = 1'b1;
      cam_data = b;
      if ((k % 2) == 0) hi = b;
      else if (capt) pix_q.push_back({hi, b});
      if (lat) begin
        if (k == 2) begin
          check("lat_valid_n", {31'd0, dvp_valid}, 32'd0);
          check("lat_href_a1", {31'd0, dvp_href}, 32'd0);
        end
        if (k == 3) begin
          check("lat_valid_n1", {31'd0, dvp_valid}, 32'd0);
          check("lat_href_a2", {31'd0, dvp_href}, 32'd1);
        end
        if (k == 4) check("lat_valid_n2", {31'd0, dvp_valid}, 32'd1);
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_vsync();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int f, input frame_vec_t v, input bit lat);
    int nb;
    for (int l = 0; l < v.n_lines; l++) begin
      nb = (l == v.short_line) ? v.n_bytes - 1 : v.n_bytes;
      send_line(f, l, nb, v.capt, lat && (l == 0));
    end
    if (v.capt) fd_q.push_back('{lines: CW'(v.exp_lines), err: v.exp_err});
    send_vsync();
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    frame_vec_t vecs[8];
    frame_vec_t v;
    vecs[0] = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 0, exp_lines: 0, exp_err: 0};
    vecs[1] = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 0, exp_lines: 0, exp_err: 0};
    vecs[2] = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 2, exp_err: 0};
    vecs[3] = '{n_lines: 2, n_bytes: 8, short_line:  0, capt: 1, exp_lines: 2, exp_err: 1};
    vecs[4] = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 2, exp_err: 0};
    vecs[5] = '{n_lines: 3, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 3, exp_err: 1};
    vecs[6] = '{n_lines: 2, n_bytes: 6, short_line: -1, capt: 1, exp_lines: 2, exp_err: 1};
    vecs[7] = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 2, exp_err: 0};

    rst_n = 1'b0;
    rst0_n = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = '0;
    repeat (3) @(negedge clk);
    check("rst_dvp_valid", {31'd0, dvp_valid}, 32'd0);
    check("rst_dvp_href", {31'd0, dvp_href}, 32'd0);
    check("rst_dvp_data", {16'd0, dvp_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_line_cnt", {20'd0, line_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames: two settle frames, then captured frames.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      send_frame(i, v, i == 2);
    end

    // Mid-frame reset: frame abandoned, then two more frames skipped.
    send_line(10, 0, 8, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dvp_valid", {31'd0, dvp_valid}, 32'd0);
    check("midrst_dvp_href", {31'd0, dvp_href}, 32'd0);
    check("midrst_dvp_vsync", {31'd0, dvp_vsync}, 32'd0);
    check("midrst_dvp_data", {16'd0, dvp_data}, 32'd0);
    check("midrst_line_cnt", {20'd0, line_cnt}, 32'd0);
    check("midrst_size_err", {31'd0, size_err}, 32'd0);
    rst_n = 1'b1;
    send_line(10, 1, 8, 1'b0, 1'b0);
    send_vsync();
    v = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 0, exp_lines: 0, exp_err: 0};
    send_frame(11, v, 1'b0);
    v = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 2, exp_err: 0};
    send_frame(12, v, 1'b0);

    // FRAME_SKIP=0 instance leaves reset during vsync-low mid-frame.
    send_line(20, 0, 8, 1'b1, 1'b0);
    rst0_n = 1'b1;
    send_line(20, 1, 8, 1'b1, 1'b0);
    fd_q.push_back('{lines: CW'(2), err: 1'b0});
    send_vsync();
    check("fs0_no_valid_before_boundary", v0_cnt, 32'd0);
    check("fs0_no_fd_before_boundary", fd0_cnt, 32'd0);
    v = '{n_lines: 2, n_bytes: 8, short_line: -1, capt: 1, exp_lines: 2, exp_err: 0};
    send_frame(21, v, 1'b0);
    repeat (4) @(negedge clk);
    check("fs0_valid_count", v0_cnt, 32'd8);
    check("fs0_fd_count", fd0_cnt, 32'd1);
    check("fs0_line_cnt", {20'd0, fd0_lines}, 32'd2);
    check("fs0_size_err", {31'd0, fd0_err}, 32'd0);
    check("fs0_last_pixel", {16'd0, last0}, {16'd0, byte_val(21, 1, 6), byte_val(21, 1, 7)});

    repeat (5) @(negedge clk);
    check("pixels_outstanding", pix_q.size(), 32'd0);
    check("frame_done_outstanding", fd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
